// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 slave exposing NREG x NBIT control registers behind one chip select.
// Build option SPI_BURST_EN: consecutive data words in one frame auto-increment the register index.
`timescale 1ns/1ps
module spi_reg_bank #(
   parameter int unsigned     NBIT      = 8,
   parameter int unsigned     NREG      = 4,
   parameter int unsigned     BASE_ADR  = 1,
   parameter logic [NBIT-1:0] RESET_VAL = '0
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        sclk,
   input  logic                                        cs,
   input  logic                                        mosi,
   output logic                                        miso,
   output logic [NREG*NBIT-1:0]                        regs_out,
   output logic                                        wr_stb,
   output logic [((NREG > 1) ? $clog2(NREG) : 1)-1:0]  wr_idx,
   output logic                                        busy
);

   localparam int unsigned IDXW     = (NREG > 1) ? $clog2(NREG) : 1;
   localparam int unsigned HI_INT   = (BASE_ADR + NREG - 1 > 127) ? 127 : BASE_ADR + NREG - 1;
   localparam logic [6:0]  ADR_LO   = BASE_ADR[6:0];
   localparam logic [6:0]  ADR_HI   = HI_INT[6:0];
   localparam logic [5:0]  HDR_LAST = 6'd7;
   localparam logic [5:0]  DAT_LAST = 6'(NBIT - 1);
`ifdef SPI_BURST_EN
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NREG - 1);
`endif

   typedef enum logic [1:0] {IDLE, HDR, DATA, SKIP} state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [2:0]        r_sclk_sync;
   logic [2:0]        r_cs_sync;
   logic [2:0]        r_mosi_sync;

   logic [5:0]        r_cnt;
   logic [6:0]        r_hdr;
   logic              r_wr_mode;
   logic [IDXW-1:0]   r_idx;
   logic [NBIT-1:0]   r_shift;
   logic [NBIT-1:0]   r_regs [NREG];
   logic              r_wr_stb;
   logic [IDXW-1:0]   r_wr_idx;

   logic              w_sclk_rise;
   logic              w_sclk_fall;
   logic              w_cs_rise;
   logic              w_cs_fall;
   logic              w_mosi;
   logic [6:0]        w_hdr_adr;
   logic              w_in_range;
   logic [IDXW-1:0]   w_hdr_idx;
   logic [NBIT-1:0]   w_word;
   logic              w_hdr_done;
   logic              w_word_done;
`ifdef SPI_BURST_EN
   logic              w_burst_go;
   logic [IDXW-1:0]   w_idx_inc;
`endif

   // Index [0] is the newest sample; edges are judged on the two oldest taps.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sclk_sync <= '0;
         r_cs_sync   <= '0;
         r_mosi_sync <= '0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[1:0], sclk};
         r_cs_sync   <= {r_cs_sync[1:0], cs};
         r_mosi_sync <= {r_mosi_sync[1:0], mosi};
      end
   end

   assign w_sclk_rise = (r_sclk_sync[2:1] == 2'b01);
   assign w_sclk_fall = (r_sclk_sync[2:1] == 2'b10);
   assign w_cs_rise   = (r_cs_sync[2:1] == 2'b01);
   assign w_cs_fall   = (r_cs_sync[2:1] == 2'b10);
   assign w_mosi      = r_mosi_sync[1];

   assign w_hdr_adr  = {r_hdr[5:0], w_mosi};
   assign w_in_range = (w_hdr_adr >= ADR_LO) && (w_hdr_adr <= ADR_HI);
   assign w_hdr_idx  = IDXW'(w_hdr_adr - ADR_LO);
   assign w_word     = {r_shift[NBIT-2:0], w_mosi};
`ifdef SPI_BURST_EN
   assign w_idx_inc  = r_idx + IDXW'(1);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_hdr_done  = 1'b0;
      w_word_done = 1'b0;
`ifdef SPI_BURST_EN
      w_burst_go  = 1'b0;
`endif
      if (w_cs_rise) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_cs_fall) w_state_nxt = HDR;
            end
            HDR: begin
               if (w_sclk_rise && r_cnt == HDR_LAST) begin
                  w_hdr_done  = 1'b1;
                  w_state_nxt = w_in_range ? DATA : SKIP;
               end
            end
            DATA: begin
               if (w_sclk_rise && r_cnt == DAT_LAST) begin
                  w_word_done = 1'b1;
`ifdef SPI_BURST_EN
                  if (r_idx == IDX_LAST) w_state_nxt = SKIP;
                  else                   w_burst_go  = 1'b1;
`else
                  w_state_nxt = SKIP;
`endif
               end
            end
            default: ;
         endcase
      end
   end

   // r_shift serves both directions: it collects write data, or holds read data and
   // shifts on sclk falls once the first data rise has passed.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt     <= '0;
         r_hdr     <= '0;
         r_wr_mode <= 1'b0;
         r_idx     <= '0;
         r_shift   <= '0;
         r_wr_stb  <= 1'b0;
         r_wr_idx  <= '0;
         for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= RESET_VAL;
      end else begin
         r_wr_stb <= 1'b0;
         if (w_cs_rise) begin
            r_cnt <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  r_cnt <= '0;
               end
               HDR: begin
                  if (w_sclk_rise) begin
                     r_hdr <= {r_hdr[5:0], w_mosi};
                     r_cnt <= r_cnt + 6'd1;
                     if (w_hdr_done) begin
                        r_cnt     <= '0;
                        r_wr_mode <= r_hdr[6];
                        r_idx     <= w_hdr_idx;
                        if (w_in_range) r_shift <= r_regs[w_hdr_idx];
                     end
                  end
               end
               DATA: begin
                  if (w_sclk_rise) begin
                     r_cnt <= r_cnt + 6'd1;
                     if (r_wr_mode) r_shift <= w_word;
                     if (w_word_done) begin
                        r_cnt <= '0;
                        if (r_wr_mode) begin
                           r_regs[r_idx] <= w_word;
                           r_wr_stb      <= 1'b1;
                           r_wr_idx      <= r_idx;
                        end
`ifdef SPI_BURST_EN
                        if (w_burst_go) begin
                           r_idx <= w_idx_inc;
                           if (!r_wr_mode) r_shift <= r_regs[w_idx_inc];
                        end
`endif
                     end
                  end else if (w_sclk_fall && !r_wr_mode && r_cnt != '0) begin
                     r_shift <= {r_shift[NBIT-2:0], 1'b0};
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      regs_out = '0;
      for (int unsigned i = 0; i < NREG; i++) regs_out[i*NBIT +: NBIT] = r_regs[i];
   end

   assign miso   = (r_state == DATA && !r_wr_mode) ? r_shift[NBIT-1] : 1'b1;
   assign busy   = (r_state != IDLE);
   assign wr_stb = r_wr_stb;
   assign wr_idx = r_wr_idx;

endmodule
